// File: rtl/vga_frame_engine.sv
// Parametrised VGA raster engine: timing, framebuffer requests, ball sprite.
// Optional colour-bar test pattern on mode 3 when VGA_TEST_PATTERN_EN is defined.
module vga_frame_engine #(
  parameter int   H_VISIBLE  = 800,
  parameter int   H_FRONT    = 56,
  parameter int   H_SYNC     = 120,
  parameter int   H_BACK     = 64,
  parameter int   V_VISIBLE  = 600,
  parameter int   V_FRONT    = 37,
  parameter int   V_SYNC     = 6,
  parameter int   V_BACK     = 23,
  parameter logic H_SYNC_POL = 1'b1,
  parameter logic V_SYNC_POL = 1'b1,
  parameter int   COLOR_W    = 4,
  parameter int   FB_LATENCY = 2,
  parameter int   BALL_SIZE  = 20,
  parameter int   BALL_STEP  = 1,
  localparam int  H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int  V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int  X_W = $clog2(H_TOTAL),
  localparam int  Y_W = $clog2(V_TOTAL)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  output logic                 fb_req,
  output logic [X_W-1:0]       fb_x,
  output logic [Y_W-1:0]       fb_y,
  input  logic [3*COLOR_W-1:0] fb_data,
  output logic [COLOR_W-1:0]   vga_red,
  output logic [COLOR_W-1:0]   vga_green,
  output logic [COLOR_W-1:0]   vga_blue,
  output logic                 h_sync,
  output logic                 v_sync,
  output logic                 frame_end
);

  localparam int CW = 3 * COLOR_W;
`ifdef VGA_TEST_PATTERN_EN
  localparam int PW = 4 + CW;
`else
  localparam int PW = 4;
`endif
  localparam logic [PW-1:0] STG_RST =
    PW'({1'b0, ~H_SYNC_POL, ~V_SYNC_POL, 1'b0});

  logic [X_W-1:0] x, ball_x, ball_x_n;
  logic [Y_W-1:0] y, ball_y, ball_y_n;
  logic           dx, dy, dx_n, dy_n;
  logic [1:0]     mode_q;
  logic           x_last, y_last;
  logic           vis, hs, vs, hit;
  logic [PW-1:0]  cur, dly;
  logic [CW-1:0]  col;

  assign x_last    = (x == X_W'(H_TOTAL - 1));
  assign y_last    = (y == Y_W'(V_TOTAL - 1));
  assign frame_end = x_last && y_last;
  assign vis       = (int'(x) < H_VISIBLE) && (int'(y) < V_VISIBLE);
  assign fb_req    = vis;
  assign fb_x      = x;
  assign fb_y      = y;

  // Raster counters, frame-boundary mode latch and ball state
  always_ff @(posedge clk) begin
    if (rst) begin
      x      <= '0;
      y      <= '0;
      mode_q <= '0;
      ball_x <= '0;
      ball_y <= '0;
      dx     <= 1'b1;
      dy     <= 1'b1;
    end else begin
      x <= x_last ? '0 : x + 1'b1;
      if (x_last) y <= y_last ? '0 : y + 1'b1;
      if (x == '0 && y == '0) mode_q <= mode;
      if (frame_end) begin
        ball_x <= ball_x_n;
        ball_y <= ball_y_n;
        dx     <= dx_n;
        dy     <= dy_n;
      end
    end
  end

  // Per-axis bounce: clamp to the edge and reverse on overshoot
  always_comb begin
    ball_x_n = ball_x;
    ball_y_n = ball_y;
    dx_n     = dx;
    dy_n     = dy;
    if (dx) begin
      if (int'(ball_x) + BALL_STEP + BALL_SIZE > H_VISIBLE) begin
        ball_x_n = X_W'(H_VISIBLE - BALL_SIZE);
        dx_n     = 1'b0;
      end else ball_x_n = ball_x + X_W'(BALL_STEP);
    end else begin
      if (int'(ball_x) < BALL_STEP) begin
        ball_x_n = '0;
        dx_n     = 1'b1;
      end else ball_x_n = ball_x - X_W'(BALL_STEP);
    end
    if (dy) begin
      if (int'(ball_y) + BALL_STEP + BALL_SIZE > V_VISIBLE) begin
        ball_y_n = Y_W'(V_VISIBLE - BALL_SIZE);
        dy_n     = 1'b0;
      end else ball_y_n = ball_y + Y_W'(BALL_STEP);
    end else begin
      if (int'(ball_y) < BALL_STEP) begin
        ball_y_n = '0;
        dy_n     = 1'b1;
      end else ball_y_n = ball_y - Y_W'(BALL_STEP);
    end
  end

  assign hs  = ((int'(x) >= H_VISIBLE + H_FRONT) &&
                (int'(x) <  H_VISIBLE + H_FRONT + H_SYNC))
               ? H_SYNC_POL : ~H_SYNC_POL;
  assign vs  = ((int'(y) >= V_VISIBLE + V_FRONT) &&
                (int'(y) <  V_VISIBLE + V_FRONT + V_SYNC))
               ? V_SYNC_POL : ~V_SYNC_POL;
  assign hit = (int'(x) >= int'(ball_x)) &&
               (int'(x) <  int'(ball_x) + BALL_SIZE) &&
               (int'(y) >= int'(ball_y)) &&
               (int'(y) <  int'(ball_y) + BALL_SIZE);

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0]    bar;
  logic [CW-1:0] tp_col, tp_d;

  // Bar index by threshold compares: bar = x*8/H_VISIBLE
  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++)
      if (int'(x) * 8 >= k * H_VISIBLE) bar = 3'(k);
  end

  assign tp_col = {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}},
                   {COLOR_W{bar[0]}}};
  assign cur    = {tp_col, vis, hs, vs, hit};
  assign tp_d   = dly[PW-1:4];
`else
  assign cur = {vis, hs, vs, hit};
`endif

  generate
    if (FB_LATENCY == 0) begin : g_nodly
      assign dly = cur;
    end else begin : g_dly
      logic [PW-1:0] pipe [FB_LATENCY];
      // Delay flags to line up with the framebuffer read data
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < FB_LATENCY; i++) pipe[i] <= STG_RST;
        end else begin
          pipe[0] <= cur;
          for (int i = 1; i < FB_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign dly = pipe[FB_LATENCY-1];
    end
  endgenerate

  // Colour select on the delayed flags, blanked outside visible
  always_comb begin
    col = '0;
    case (mode_q)
      2'd0:    col = fb_data;
      2'd1:    col = dly[0] ? '1 : '0;
      2'd2:    col = dly[0] ? '1 : fb_data;
`ifdef VGA_TEST_PATTERN_EN
      default: col = tp_d;
`else
      default: col = '0;
`endif
    endcase
    if (!dly[3]) col = '0;
  end

  // Output register
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_red   <= '0;
      vga_green <= '0;
      vga_blue  <= '0;
      h_sync    <= ~H_SYNC_POL;
      v_sync    <= ~V_SYNC_POL;
    end else begin
      vga_red   <= col[CW-1:2*COLOR_W];
      vga_green <= col[2*COLOR_W-1:COLOR_W];
      vga_blue  <= col[COLOR_W-1:0];
      h_sync    <= dly[2];
      v_sync    <= dly[1];
    end
  end

endmodule

// File: tb/tb_vga_frame_engine.sv
// Directed bench: small raster config plus an 800x600 default instance.
// Pixel p of a run appears on the outputs after edge p+3.
module tb_vga_frame_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    = 1'b1;
  logic [1:0]  mode   = 2'd0;
  logic [1:0]  mode_d = 2'd3;

  logic        fb_req, h_sync, v_sync, frame_end;
  logic [3:0]  fb_x, red, green, blue;
  logic [2:0]  fb_y;
  logic [11:0] fb_data, m1, m2;

  logic        fb_req_d, h_sync_d, v_sync_d, frame_end_d;
  logic [10:0] fb_x_d;
  logic [9:0]  fb_y_d;
  logic [3:0]  red_d, green_d, blue_d;
  logic [11:0] fb_data_d;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  vga_frame_engine #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .FB_LATENCY(2), .BALL_SIZE(2), .BALL_STEP(1)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .fb_req(fb_req), .fb_x(fb_x), .fb_y(fb_y),
    .fb_data(fb_data),
    .vga_red(red), .vga_green(green), .vga_blue(blue),
    .h_sync(h_sync), .v_sync(v_sync), .frame_end(frame_end)
  );

  vga_frame_engine dut_d (
    .clk(clk), .rst(rst), .mode(mode_d),
    .fb_req(fb_req_d), .fb_x(fb_x_d), .fb_y(fb_y_d),
    .fb_data(fb_data_d),
    .vga_red(red_d), .vga_green(green_d), .vga_blue(blue_d),
    .h_sync(h_sync_d), .v_sync(v_sync_d), .frame_end(frame_end_d)
  );

  assign fb_data_d = 12'h000;

  always @(posedge clk) begin
    m1 <= {fb_x, 1'b0, fb_y, 4'h0};
    m2 <= m1;
  end
  assign fb_data = m2;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic do_reset(input logic [1:0] m);
    rst  = 1'b1;
    mode = m;
    step();
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic scan_ball(input int ex, input int ey);
    int p, x, y;
    logic [11:0] exp;
    for (int i = 0; i < 98; i++) begin
      step();
      p = cyc - 3;
      x = p % 14;
      y = (p / 14) % 7;
      exp = 12'h000;
      if (x < 8 && y < 4 && x >= ex && x < ex + 2 && y >= ey && y < ey + 2)
        exp = 12'hFFF;
      vectors++;
      if ({red, green, blue} !== exp) begin
        errors++;
        $display("FAIL ball(%0d,%0d) px=(%0d,%0d) got %h exp %h",
                 ex, ey, x, y, {red, green, blue}, exp);
      end
    end
  endtask

  task automatic test_reset();
    logic exp;
    rst = 1'b1;
    mode = 2'd0;
    step(); step(); step();
    vectors++;
    if ({red, green, blue, h_sync, v_sync, frame_end} !== 15'h0) begin
      errors++;
      $display("FAIL reset_out got %h exp 0",
               {red, green, blue, h_sync, v_sync, frame_end});
    end
    vectors++;
    if ({fb_x, fb_y, fb_req} !== 8'h01) begin
      errors++;
      $display("FAIL reset_ctr got %h exp 01", {fb_x, fb_y, fb_req});
    end
    rst = 1'b0;
    cyc = 0;
    for (int j = 1; j <= 15; j++) begin
      step();
      exp = (cyc == 13 || cyc == 14);
      vectors++;
      if (h_sync !== exp) begin
        errors++;
        $display("FAIL hsync_release cyc=%0d got %b exp %b",
                 cyc, h_sync, exp);
      end
    end
  endtask

  task automatic test_fb();
    int p, x, y;
    logic [13:0] exp;
    logic fe;
    do_reset(2'd0);
    for (int i = 0; i < 101; i++) begin
      step();
      p = cyc - 3;
      exp = 14'h0;
      if (p >= 0) begin
        x = p % 14;
        y = (p / 14) % 7;
        if (x < 8 && y < 4) exp[13:2] = {4'(x), 4'(y), 4'h0};
        exp[1] = (x == 10 || x == 11);
        exp[0] = (y == 5);
      end
      vectors++;
      if ({red, green, blue, h_sync, v_sync} !== exp) begin
        errors++;
        $display("FAIL fb_pixel p=%0d got %h exp %h",
                 p, {red, green, blue, h_sync, v_sync}, exp);
      end
      fe = (cyc % 98 == 97);
      vectors++;
      if (frame_end !== fe) begin
        errors++;
        $display("FAIL frame_end cyc=%0d got %b exp %b", cyc, frame_end, fe);
      end
    end
  endtask

  task automatic test_mode_change();
    do_reset(2'd0);
    run_to(129);
    mode = 2'd1;
    run_to(148);
    vectors++;
    if ({red, green, blue} !== 12'h530) begin
      errors++;
      $display("FAIL mode_hold got %h exp 530", {red, green, blue});
    end
    run_to(150);
    vectors++;
    if ({red, green, blue} !== 12'h730) begin
      errors++;
      $display("FAIL mode_hold2 got %h exp 730", {red, green, blue});
    end
    run_to(217);
    vectors++;
    if ({red, green, blue} !== 12'h000) begin
      errors++;
      $display("FAIL mode_switch_bg got %h exp 000", {red, green, blue});
    end
    run_to(229);
    vectors++;
    if ({red, green, blue} !== 12'hFFF) begin
      errors++;
      $display("FAIL mode_switch_ball got %h exp FFF", {red, green, blue});
    end
  endtask

  task automatic test_pattern();
    logic [11:0] e0, e1, e2;
`ifdef VGA_TEST_PATTERN_EN
    e0 = 12'h000; e1 = 12'h00F; e2 = 12'hFFF;
`else
    e0 = 12'h000; e1 = 12'h000; e2 = 12'h000;
`endif
    do_reset(2'd0);
    run_to(3);
    vectors++;
    if ({red_d, green_d, blue_d} !== e0) begin
      errors++;
      $display("FAIL tp_x0 got %h exp %h", {red_d, green_d, blue_d}, e0);
    end
    run_to(103);
    vectors++;
    if ({red_d, green_d, blue_d} !== e1) begin
      errors++;
      $display("FAIL tp_x100 got %h exp %h", {red_d, green_d, blue_d}, e1);
    end
    run_to(802);
    vectors++;
    if ({red_d, green_d, blue_d} !== e2) begin
      errors++;
      $display("FAIL tp_x799 got %h exp %h", {red_d, green_d, blue_d}, e2);
    end
  endtask

  task automatic test_ball();
    int ebx [10] = '{0, 1, 2, 3, 4, 5, 6, 6, 5, 4};
    int eby [10] = '{0, 1, 2, 2, 1, 0, 0, 1, 2, 2};
    do_reset(2'd1);
    for (int f = 0; f < 10; f++) begin
      run_to(2 + 98 * f);
      scan_ball(ebx[f], eby[f]);
    end
  endtask

  task automatic test_reset_mid();
    run_to(1027);
    rst = 1'b1;
    step();
    vectors++;
    if ({red, green, blue, h_sync, v_sync, frame_end} !== 15'h0) begin
      errors++;
      $display("FAIL midrst_out got %h exp 0",
               {red, green, blue, h_sync, v_sync, frame_end});
    end
    vectors++;
    if ({fb_x, fb_y} !== 7'h0) begin
      errors++;
      $display("FAIL midrst_ctr got %h exp 0", {fb_x, fb_y});
    end
    rst = 1'b0;
    cyc = 0;
    run_to(2);
    scan_ball(0, 0);
  endtask

  initial begin
    test_reset();
    test_fb();
    test_mode_change();
    test_pattern();
    test_ball();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/vga_frame_engine.md
# vga_frame_engine

Parametrised VGA raster engine that succeeds the fixed 800x600@72 Hz controller. It generates horizontal and vertical timing from parameters and issues per-pixel read requests to an external framebuffer with configurable read latency. Sync and blanking are delay-matched to the returned pixel data. A bouncing-ball sprite, with edge reflection, can be overlaid on the framebuffer data. The block sits between the memory-mapped framebuffer and the board VGA DAC pins.

## Interface
- H_VISIBLE, 800, active pixels per line
- H_FRONT, 56, horizontal front porch (pixels)
- H_SYNC, 120, horizontal sync width (pixels)
- H_BACK, 64, horizontal back porch (pixels)
- V_VISIBLE, 600, active lines per frame
- V_FRONT, 37, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BACK, 23, vertical back porch (lines)
- H_SYNC_POL, 1, level of h_sync during the sync pulse
- V_SYNC_POL, 1, level of v_sync during the sync pulse
- COLOR_W, 4, bits per colour channel
- FB_LATENCY, 2, cycles from fb_req to valid fb_data; legal range 0..7
- BALL_SIZE, 20, sprite edge length in pixels
- BALL_STEP, 1, sprite displacement per frame and axis, in pixels
- X_W / Y_W, derived, $clog2(H_total) / $clog2(V_total)

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- mode  in  2  0 = framebuffer, 1 = ball on black, 2 = framebuffer with ball overlay, 3 = test pattern
- fb_req  out  1  high when the current counter position is visible
- fb_x  out  X_W  pixel column of the request
- fb_y  out  Y_W  pixel row of the request
- fb_data  in  3*COLOR_W  {r,g,b}, valid FB_LATENCY cycles after fb_req
- vga_red / vga_green / vga_blue  out  COLOR_W  registered colour outputs
- h_sync / v_sync  out  1  registered sync outputs
- frame_end  out  1  one-cycle pulse at counter position (H_total-1, V_total-1); not delayed

## Operation
- Totals: H_total = H_VISIBLE + H_FRONT + H_SYNC + H_BACK; V_total is formed the same way from the V_ parameters.
- Counters:
  - x counts 0..H_total-1 and wraps to 0.
  - y increments when x wraps, counts 0..V_total-1, and wraps to 0.
- Visible region: x < H_VISIBLE && y < V_VISIBLE.
- Sync pulses:
  - h_sync is active when H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC.
  - v_sync is active for the same window in y.
- fb_req, fb_x and fb_y are combinational from the counters. fb_x and fb_y are driven with the counter values even when fb_req=0.
- Mode latch: `mode` is sampled into mode_q only when the counter is at (0,0). A mode change therefore never takes effect mid-frame.
- Ball sprite:
  - State is ball_x, ball_y, dx, dy. Reset values: position (0,0), dx = dy = +1 (moving right and down).
  - The ball covers ball_x <= x < ball_x+BALL_SIZE and ball_y <= y < ball_y+BALL_SIZE.
  - Update happens only in the frame_end cycle, with each axis handled independently.
  - Moving positive: if pos+BALL_STEP+BALL_SIZE > VISIBLE, set pos = VISIBLE-BALL_SIZE and flip direction; otherwise pos += BALL_STEP.
  - Moving negative: if pos < BALL_STEP, set pos = 0 and flip direction; otherwise pos -= BALL_STEP.
  - Ball pixels are all-ones on every channel.
- Colour select, applied at the output stage:
  - mode 0: fb_data
  - mode 1: white inside the ball, black elsewhere
  - mode 2: ball pixels take priority, fb_data elsewhere
  - mode 3: test pattern (see Configuration)
  - Colour is forced to 0 whenever the delayed visible flag is 0.

## Timing
- Pipeline: counter, then FB_LATENCY delay stages, then the output register. Output latency is FB_LATENCY+1 cycles from the counter.
- The visible flag, h/v sync, ball-hit bit and test-pattern colour are carried through FB_LATENCY stages of shift registers, so they align exactly with fb_data.
- Reset, effective on the first clk edge with rst=1:
  - x, y, ball position and mode_q are cleared to 0.
  - All delay stages are cleared to blank and sync-inactive.
  - vga_* = 0, h_sync = ~H_SYNC_POL, v_sync = ~V_SYNC_POL, frame_end = 0.
- Reset mid-frame discards the frame in progress. The first valid pixel appears FB_LATENCY+1 cycles after rst is released.
- frame_end coincides with the ball update. The next frame, starting at (0,0), uses the new position.

## Configuration
- VGA_TEST_PATTERN_EN
  - Defined: mode 3 produces eight vertical colour bars. bar = x*8/H_VISIBLE, computed by threshold compares (no divider). The colour is r = bar[2], g = bar[1], b = bar[0], each replicated COLOR_W times, so bar 0 is black and bar 7 is white.
  - Undefined: mode 3 outputs black during visible time, no bar logic is synthesised, and syncs are unchanged.

## Test plan
Tests 1-4 use a small config: H = 8/2/2/2 (H_total 14), V = 4/1/1/1 (V_total 7), FB_LATENCY=2, BALL_SIZE=2, BALL_STEP=1.

1. Reset hold → all outputs at reset values. After release, h_sync=~POL for 13 cycles, then POL for exactly 2 cycles: counter x = 10..11, observed on the outputs at release+3+10.
2. mode 0 with fb_data = {fb_x, fb_y} (combined with the 2-cycle model latency) → vga_red equals the pixel's x 3 cycles after each request. Outputs are 0 during x = 8..13.
3. mode 1 for 10 frames → ball_x follows 0,1,2,3,4,5,6,6,5,4 (reflection at H_VISIBLE-BALL_SIZE = 6), and ball_y follows 0,1,2,2,1,0,0,1,2,2.
4. Change mode from 0 to 1 at (3,2) → the output remains framebuffer data until the next (0,0), then switches to ball.
5. VGA_TEST_PATTERN_EN with 800x600 defaults, mode 3 → x=0 gives black, x=100 gives {0,0,F}, x=799 gives {F,F,F}. With the macro undefined → all black.
6. rst asserted at (5,3) for 1 cycle → the next edge shows reset outputs and x=y=0. Ball position returns to (0,0).
